// File: rtl/tc_ram_arbiter.sv
// tc_ram_arbiter
// Shares one single-port TC_Ram (64-bit word, lane 0) between two masters.
// Each master issues read/write commands on a valid/ready request channel and
// receives the result on a valid/ready response channel. One command is in
// flight at a time: IDLE (grant) -> ACCESS (one RAM cycle) -> RESP (hold until
// the winner takes the response).
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_*_{0,1}_i/_o        command channel per requester (valid/ready/write/addr/wdata)
//   rsp_*_{0,1}_i/_o        response channel per requester (valid/ready/rdata/err)
//   ram_load_o, ram_save_o  RAM strobes, high only during ACCESS
//   ram_address_o, ram_in0_o RAM address / write data, 0 outside ACCESS
//   ram_out0_i              RAM read data, captured at the end of ACCESS
module tc_ram_arbiter #(
    parameter int unsigned WORD_COUNT = 256,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req_valid_0_i,
    output logic              req_ready_0_o,
    input  logic              req_write_0_i,
    input  logic [ADDR_W-1:0] req_addr_0_i,
    input  logic [63:0]       req_wdata_0_i,
    output logic              rsp_valid_0_o,
    input  logic              rsp_ready_0_i,
    output logic [63:0]       rsp_rdata_0_o,
    output logic              rsp_err_0_o,

    input  logic              req_valid_1_i,
    output logic              req_ready_1_o,
    input  logic              req_write_1_i,
    input  logic [ADDR_W-1:0] req_addr_1_i,
    input  logic [63:0]       req_wdata_1_i,
    output logic              rsp_valid_1_o,
    input  logic              rsp_ready_1_i,
    output logic [63:0]       rsp_rdata_1_o,
    output logic              rsp_err_1_o,

    output logic              ram_load_o,
    output logic              ram_save_o,
    output logic [ADDR_W-1:0] ram_address_o,
    output logic [63:0]       ram_in0_o,
    input  logic [63:0]       ram_out0_i
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e              state_q;
    logic                last_grant_q;
    logic                win_q;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [63:0]         wdata_q;
    logic [63:0]         rdata_q;
    logic                err_q;

    logic                grant_valid;
    logic                grant_id;
    logic                in_range;
    logic                rsp_ready_win;

    // Round-robin: on a tie the requester that was not served last wins;
    // a lone requester always wins.
    always_comb begin
        grant_valid = req_valid_0_i | req_valid_1_i;
        if (req_valid_0_i && req_valid_1_i) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req_valid_1_i;
        end
    end

    // Widen both sides so the compare is safe for any ADDR_W.
    assign in_range      = (64'(addr_q) < 64'(WORD_COUNT));
    assign rsp_ready_win = win_q ? rsp_ready_1_i : rsp_ready_0_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            win_q        <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        win_q   <= grant_id;
                        write_q <= grant_id ? req_write_1_i : req_write_0_i;
                        addr_q  <= grant_id ? req_addr_1_i  : req_addr_0_i;
                        wdata_q <= grant_id ? req_wdata_1_i : req_wdata_0_i;
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    rdata_q <= (!write_q && in_range) ? ram_out0_i : 64'd0;
                    err_q   <= ~in_range;
                    state_q <= StResp;
                end
                StResp: begin
                    if (rsp_ready_win) begin
                        last_grant_q <= win_q;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Everything is forced low while rst_i is high so an aborted write never
    // reaches the RAM and no handshake can complete during reset.
    always_comb begin
        req_ready_0_o = 1'b0;
        req_ready_1_o = 1'b0;
        rsp_valid_0_o = 1'b0;
        rsp_valid_1_o = 1'b0;
        rsp_rdata_0_o = 64'd0;
        rsp_rdata_1_o = 64'd0;
        rsp_err_0_o   = 1'b0;
        rsp_err_1_o   = 1'b0;
        ram_load_o    = 1'b0;
        ram_save_o    = 1'b0;
        ram_address_o = '0;
        ram_in0_o     = 64'd0;
        if (!rst_i) begin
            case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        req_ready_0_o = ~grant_id;
                        req_ready_1_o = grant_id;
                    end
                end
                StAccess: begin
                    ram_address_o = addr_q;
                    ram_in0_o     = wdata_q;
                    ram_save_o    = write_q & in_range;
                    ram_load_o    = ~write_q & in_range;
                end
                StResp: begin
                    if (win_q) begin
                        rsp_valid_1_o = 1'b1;
                        rsp_rdata_1_o = rdata_q;
                        rsp_err_1_o   = err_q;
                    end else begin
                        rsp_valid_0_o = 1'b1;
                        rsp_rdata_0_o = rdata_q;
                        rsp_err_0_o   = err_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/tc_ram_arbiter.md
# tc_ram_arbiter

Two-requester arbiter and sequencer that shares one single-port TC_Ram instance (64-bit word, lane 0 only) between two independent masters. Each master issues read/write commands over a valid/ready request channel and receives a result on a valid/ready response channel. The block drives the RAM's load/save/address/in0 pins and captures out0. It sits between the CPU-side load/store units and the shared data RAM.

## Interface
Parameters:
- WORD_COUNT, 256, number of addressable RAM words; addresses >= WORD_COUNT are rejected.
- ADDR_W, 32, address width, matching the RAM address port.

Ports (x = 0, 1, one set per requester):
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid_x  in  1  command valid.
- req_ready_x  out  1  command accepted this cycle.
- req_write_x  in  1  1 = write, 0 = read.
- req_addr_x  in  ADDR_W  word address.
- req_wdata_x  in  64  write data.
- rsp_valid_x  out  1  response valid.
- rsp_ready_x  in  1  response consumed.
- rsp_rdata_x  out  64  read data; 0 for writes and errors.
- rsp_err_x  out  1  address out of range.
- ram_load  out  1  to RAM load.
- ram_save  out  1  to RAM save.
- ram_address  out  ADDR_W  to RAM address.
- ram_in0  out  64  to RAM in0.
- ram_out0  in  64  from RAM out0.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req_valid_x is high, select a winner and assert req_ready for the winner only, combinationally, in that cycle.
  - Latch the winner's id, write, addr and wdata. Next state is ACCESS.
  - If no request is valid, stay in IDLE.
- Arbitration is round-robin via last_grant.
  - Both valid: grant goes to the requester != last_grant.
  - One valid: that requester wins, regardless of last_grant.
- ACCESS (exactly 1 cycle):
  - Drive ram_address = latched addr and ram_in0 = latched wdata.
  - Assert ram_save if write, ram_load if read.
  - Out-of-range address (addr >= WORD_COUNT): assert neither load nor save, and set the err flag.
  - On the posedge ending ACCESS, capture ram_out0 into the rdata register for in-range reads. Capture 0 otherwise.
  - Next state is RESP.
- RESP:
  - Assert rsp_valid for the winner only, with rsp_rdata and rsp_err held stable.
  - Hold until rsp_ready for the winner is high. On that posedge, set last_grant = winner and go to IDLE.
- Outside ACCESS, ram_load, ram_save, ram_address and ram_in0 are all 0.
- The non-winner's rsp_valid and req_ready stay 0 throughout.
- Requesters keep req_valid and the command fields stable until req_ready. Commands are never dropped or reordered per requester.
- Only one command is in flight at a time. A new grant is issued only in IDLE.

## Timing
- Reset values:
  - State = IDLE; last_grant = 1, so requester 0 wins the first tie.
  - All req_ready, rsp_valid, rsp_err = 0; all rsp_rdata = 0.
  - ram_load, ram_save = 0; ram_address, ram_in0 = 0.
- Latency:
  - Accept in cycle N. ACCESS in N+1; the RAM write completes on the negedge inside N+1.
  - rsp_valid is high from N+2.
  - Earliest next accept is the cycle after the response handshake. Peak throughput is 1 op per 3 cycles.
- rsp_ready already high in the first RESP cycle: the handshake completes in that cycle and IDLE is entered in the next.
- Reset mid-operation:
  - rst is sampled at posedge and aborts any command. No response is issued and ram_save drops in the same cycle.
  - A write whose ACCESS cycle completed before the reset edge remains in RAM.
- Back-to-back requests from the same requester while the other requester is waiting: grants alternate strictly.

## Test plan
- Write then read: req0 write addr 5, data 0xDEADBEEF_00000001, then req0 read addr 5 -> ram_save high for 1 cycle at N+1; the read returns 0xDEADBEEF_00000001 with rsp_err 0 at N+2.
- Tie after reset: req0 and req1 both valid in cycle 0 -> req_ready_0 first. req1 is served next; on the next tie, req0 wins again (strict alternation).
- Out of range: read addr 256 with WORD_COUNT 256 -> ram_load and ram_save stay 0; rsp_err 1, rsp_rdata 0.
- Response backpressure: hold rsp_ready_1 low for 5 cycles -> rsp_valid_1 and rsp_rdata_1 stay stable; req_ready_0 stays 0 despite req_valid_0.
- Reset during ACCESS of a write: rst high at that posedge -> no rsp_valid; all outputs 0 in the next cycle; FSM in IDLE with last_grant 1.
- Single requester streaming: 4 reads from req1, rsp_ready tied high -> accepts at cycles 0, 3, 6, 9.
